// File: rtl/io_input_handshake_if.sv
// CPU-side handshake between the processor datapath and the board input block.
//
// Handshake: input_flag is the request and stays high for as long as the IN
// instruction executes. The responder holds cpu_stall high while the request
// is unserved and raises input_ready for exactly one cycle when user_input
// carries the answer. The transfer happens in that cycle. Dropping input_flag
// or raising halt withdraws the request, and no input_ready follows.
interface io_input_handshake_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  halt;
  logic                  input_flag;
  logic [DATA_WIDTH-1:0] user_input;
  logic                  input_ready;
  logic                  cpu_stall;

  // Processor side: issues the request, consumes the answer.
  modport master (
    output halt,
    output input_flag,
    input  user_input,
    input  input_ready,
    input  cpu_stall
  );

  // Input block side: serves the request.
  modport slave (
    input  halt,
    input  input_flag,
    output user_input,
    output input_ready,
    output cpu_stall
  );
endinterface

// File: rtl/io_input_handshake.sv
// Board input path for the CPU IN instruction. The block synchronizes the
// switches and the confirm key, then debounces the key. It stalls the core
// until the user confirms with a full press/release, and returns the switch
// value zero-extended with a one-cycle input_ready pulse.
module io_input_handshake #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_WIDTH        = 15,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  io_input_handshake_if.slave   cpu,
  input  logic [SW_WIDTH-1:0]   SW,
  input  logic                  key_n,
  output logic                  input_waiting,
  output logic [DATA_WIDTH-1:0] preview,
  output logic [2:0]            state_dbg
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ARMED        = 3'd1,
    WAIT_PRESS   = 3'd2,
    WAIT_RELEASE = 3'd3,
    DONE         = 3'd4
  } state_t;

  state_t                state;
  logic                  key_meta;
  logic                  key_sync;
  logic [SW_WIDTH-1:0]   sw_meta;
  logic [SW_WIDTH-1:0]   sw_sync;
  logic                  key_db;      // debounced key, 1 = released
  logic [CNT_W-1:0]      db_cnt;
  logic                  db_flip;
  logic                  press_evt;
  logic [DATA_WIDTH-1:0] sw_ext;

  assign sw_ext    = {{(DATA_WIDTH - SW_WIDTH){1'b0}}, sw_sync};
  // The debounced key changes on the next edge when this is high.
  assign db_flip   = (key_sync != key_db) && (db_cnt == CNT_MAX);
  // An accepted released->pressed change. The switch value is captured on
  // the same edge that key_db goes low.
  assign press_evt = db_flip && key_db;

  // Two-flop synchronizers for the asynchronous key and switch inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
    end
  end

  // Debounce: accept a new key level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_db <= 1'b1;
      db_cnt <= '0;
    end else if (key_sync == key_db) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      key_db <= key_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // Request FSM. An abort (halt or a withdrawn request) overrides every other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cpu.user_input <= '0;
    end else if ((state != IDLE) && (cpu.halt || !cpu.input_flag)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.input_flag && !cpu.halt) state <= ARMED;
        end
        // A button still held from a previous transaction must be released
        // first, so one press never satisfies two requests.
        ARMED: begin
          if (key_db) state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (press_evt) begin
            cpu.user_input <= sw_ext;
            state          <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (key_db) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state. The stall term in IDLE uses
  // the request itself, so the core freezes in the same cycle it asks.
  always_comb begin
    cpu.input_ready = (state == DONE);
    input_waiting   = (state == ARMED) || (state == WAIT_PRESS) || (state == WAIT_RELEASE);
    cpu.cpu_stall   = !reset &&
                      (((state == IDLE) && cpu.input_flag && !cpu.halt) || input_waiting);
    preview         = sw_ext;
    state_dbg       = state;
  end

endmodule

// File: tb/tb_io_input_handshake.sv
// Directed bench for io_input_handshake with a short debounce window.
module tb_io_input_handshake;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] sw;
  logic        key_n;
  logic        input_waiting;
  logic [31:0] preview;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int ready_base;

  io_input_handshake_if #(.DATA_WIDTH(32)) cpu ();

  io_input_handshake #(
    .DEBOUNCE_CYCLES(4),
    .SW_WIDTH(15),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu(cpu),
    .SW(sw),
    .key_n(key_n),
    .input_waiting(input_waiting),
    .preview(preview),
    .state_dbg(state_dbg)
  );

  // Clock and ready-pulse counter.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cpu.input_ready === 1'b1) ready_cnt = ready_cnt + 1;
  end

  // Advance n clock edges and stop 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu.halt = 1'b0; cpu.input_flag = 1'b0; key_n = 1'b1; sw = '0;
    tick(2);
    checks++; if (cpu.user_input !== 32'h0) begin errors++; $display("FAIL reset_user_input: got %h expected %h", cpu.user_input, 32'h0); end
    checks++; if (cpu.input_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cpu.input_ready); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    checks++; if (preview !== 32'h0) begin errors++; $display("FAIL reset_preview: got %h expected 0", preview); end
    cpu.input_flag = 1'b1; #1;
    checks++; if (cpu.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", cpu.cpu_stall); end
    cpu.input_flag = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_preview();
    sw = 15'h7FFF;
    tick(1);
    checks++; if (preview !== 32'h0) begin errors++; $display("FAIL preview_latency1: got %h expected %h", preview, 32'h0); end
    tick(1);
    checks++; if (preview !== 32'h00007FFF) begin errors++; $display("FAIL preview_latency2: got %h expected %h", preview, 32'h00007FFF); end
    sw = '0;
    tick(2);
  endtask

  task automatic test_basic_read();
    ready_base = ready_cnt;
    sw = 15'h1234; cpu.input_flag = 1'b1; #1;
    checks++; if (cpu.cpu_stall !== 1'b1) begin errors++; $display("FAIL basic_stall_req: got %b expected 1", cpu.cpu_stall); end
    tick(1);
    checks++; if (state_dbg !== 3'd1 || input_waiting !== 1'b1) begin errors++; $display("FAIL basic_armed: state %0d waiting %b expected 1 1", state_dbg, input_waiting); end
    tick(1);
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL basic_wait_press: got %0d expected 2", state_dbg); end
    key_n = 1'b0;
    tick(5);
    checks++; if (cpu.user_input !== 32'h0) begin errors++; $display("FAIL basic_early_capture: got %h expected %h", cpu.user_input, 32'h0); end
    tick(1);
    checks++; if (cpu.user_input !== 32'h00001234 || state_dbg !== 3'd3) begin errors++; $display("FAIL basic_capture: user_input %h state %0d expected 00001234 3", cpu.user_input, state_dbg); end
    tick(4);
    key_n = 1'b1;
    tick(6);
    checks++; if (cpu.input_ready !== 1'b0 || cpu.cpu_stall !== 1'b1) begin errors++; $display("FAIL basic_pre_ready: ready %b stall %b expected 0 1", cpu.input_ready, cpu.cpu_stall); end
    tick(1);
    checks++; if (cpu.input_ready !== 1'b1 || cpu.cpu_stall !== 1'b0) begin errors++; $display("FAIL basic_ready: ready %b stall %b expected 1 0", cpu.input_ready, cpu.cpu_stall); end
    cpu.input_flag = 1'b0;
    tick(1);
    checks++; if (cpu.input_ready !== 1'b0 || state_dbg !== 3'd0) begin errors++; $display("FAIL basic_after: ready %b state %0d expected 0 0", cpu.input_ready, state_dbg); end
    checks++; if (ready_cnt - ready_base !== 1) begin errors++; $display("FAIL basic_pulse_count: got %0d expected 1", ready_cnt - ready_base); end
  endtask

  task automatic test_bounce();
    ready_base = ready_cnt;
    sw = 15'h0AAA; cpu.input_flag = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    checks++; if (state_dbg !== 3'd2 || cpu.user_input !== 32'h00001234) begin errors++; $display("FAIL bounce_no_capture: state %0d user_input %h expected 2 00001234", state_dbg, cpu.user_input); end
    checks++; if (preview !== 32'h00000AAA) begin errors++; $display("FAIL bounce_preview: got %h expected %h", preview, 32'h00000AAA); end
    key_n = 1'b0;
    tick(5);
    checks++; if (cpu.user_input !== 32'h00001234) begin errors++; $display("FAIL bounce_early: got %h expected %h", cpu.user_input, 32'h00001234); end
    tick(1);
    checks++; if (cpu.user_input !== 32'h00000AAA) begin errors++; $display("FAIL bounce_capture: got %h expected %h", cpu.user_input, 32'h00000AAA); end
    tick(4);
    key_n = 1'b1;
    tick(7);
    checks++; if (cpu.input_ready !== 1'b1) begin errors++; $display("FAIL bounce_ready: got %b expected 1", cpu.input_ready); end
    cpu.input_flag = 1'b0;
    tick(1);
    checks++; if (ready_cnt - ready_base !== 1) begin errors++; $display("FAIL bounce_pulse_count: got %0d expected 1", ready_cnt - ready_base); end
  endtask

  task automatic test_held_rearm();
    ready_base = ready_cnt;
    sw = 15'h7FFF; key_n = 1'b0;
    tick(8);
    cpu.input_flag = 1'b1;
    tick(10);
    checks++; if (state_dbg !== 3'd1 || cpu.cpu_stall !== 1'b1 || input_waiting !== 1'b1) begin errors++; $display("FAIL held_armed: state %0d stall %b waiting %b expected 1 1 1", state_dbg, cpu.cpu_stall, input_waiting); end
    checks++; if (cpu.user_input !== 32'h00000AAA) begin errors++; $display("FAIL held_no_capture: got %h expected %h", cpu.user_input, 32'h00000AAA); end
    key_n = 1'b1;
    tick(6);
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL held_still_armed: got %0d expected 1", state_dbg); end
    tick(1);
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL held_wait_press: got %0d expected 2", state_dbg); end
    key_n = 1'b0;
    tick(6);
    checks++; if (cpu.user_input !== 32'h00007FFF) begin errors++; $display("FAIL held_capture: got %h expected %h", cpu.user_input, 32'h00007FFF); end
    tick(4);
    key_n = 1'b1;
    tick(7);
    checks++; if (cpu.input_ready !== 1'b1) begin errors++; $display("FAIL held_ready: got %b expected 1", cpu.input_ready); end
    cpu.input_flag = 1'b0;
    tick(1);
    checks++; if (ready_cnt - ready_base !== 1) begin errors++; $display("FAIL held_pulse_count: got %0d expected 1", ready_cnt - ready_base); end
  endtask

  task automatic test_back_to_back();
    ready_base = ready_cnt;
    sw = 15'd5; cpu.input_flag = 1'b1;
    tick(2);
    key_n = 1'b0;
    tick(6);
    checks++; if (cpu.user_input !== 32'd5) begin errors++; $display("FAIL b2b_capture1: got %h expected %h", cpu.user_input, 32'd5); end
    tick(4);
    key_n = 1'b1;
    tick(7);
    checks++; if (cpu.input_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", cpu.input_ready); end
    sw = 15'd9;
    tick(1);
    checks++; if (state_dbg !== 3'd0 || cpu.cpu_stall !== 1'b1 || cpu.input_ready !== 1'b0) begin errors++; $display("FAIL b2b_idle: state %0d stall %b ready %b expected 0 1 0", state_dbg, cpu.cpu_stall, cpu.input_ready); end
    tick(2);
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL b2b_rearm: got %0d expected 2", state_dbg); end
    tick(10);
    checks++; if (state_dbg !== 3'd2 || cpu.user_input !== 32'd5) begin errors++; $display("FAIL b2b_needs_press: state %0d user_input %h expected 2 00000005", state_dbg, cpu.user_input); end
    key_n = 1'b0;
    tick(6);
    checks++; if (cpu.user_input !== 32'd9) begin errors++; $display("FAIL b2b_capture2: got %h expected %h", cpu.user_input, 32'd9); end
    tick(4);
    key_n = 1'b1;
    tick(7);
    checks++; if (cpu.input_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b expected 1", cpu.input_ready); end
    cpu.input_flag = 1'b0;
    tick(1);
    checks++; if (ready_cnt - ready_base !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", ready_cnt - ready_base); end
  endtask

  task automatic test_abort();
    ready_base = ready_cnt;
    sw = 15'h0123; cpu.input_flag = 1'b1;
    tick(2);
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL abort1_setup: got %0d expected 2", state_dbg); end
    cpu.halt = 1'b1;
    tick(1);
    checks++; if (state_dbg !== 3'd0 || cpu.cpu_stall !== 1'b0 || cpu.input_ready !== 1'b0) begin errors++; $display("FAIL abort1_idle: state %0d stall %b ready %b expected 0 0 0", state_dbg, cpu.cpu_stall, cpu.input_ready); end
    checks++; if (cpu.user_input !== 32'd9) begin errors++; $display("FAIL abort1_hold: got %h expected %h", cpu.user_input, 32'd9); end
    cpu.halt = 1'b0; cpu.input_flag = 1'b0;
    tick(3);
    sw = 15'h0456; cpu.input_flag = 1'b1;
    tick(2);
    key_n = 1'b0;
    tick(6);
    checks++; if (cpu.user_input !== 32'h00000456 || state_dbg !== 3'd3) begin errors++; $display("FAIL abort2_setup: user_input %h state %0d expected 00000456 3", cpu.user_input, state_dbg); end
    cpu.input_flag = 1'b0;
    tick(1);
    checks++; if (state_dbg !== 3'd0 || cpu.cpu_stall !== 1'b0 || cpu.input_ready !== 1'b0) begin errors++; $display("FAIL abort2_idle: state %0d stall %b ready %b expected 0 0 0", state_dbg, cpu.cpu_stall, cpu.input_ready); end
    key_n = 1'b1;
    tick(8);
    checks++; if (cpu.user_input !== 32'h00000456) begin errors++; $display("FAIL abort2_hold: got %h expected %h", cpu.user_input, 32'h00000456); end
    checks++; if (ready_cnt - ready_base !== 0) begin errors++; $display("FAIL abort_pulse_count: got %0d expected 0", ready_cnt - ready_base); end
  endtask

  task automatic test_reset_mid();
    ready_base = ready_cnt;
    sw = 15'h0321; cpu.input_flag = 1'b1;
    tick(2);
    key_n = 1'b0;
    tick(6);
    checks++; if (cpu.user_input !== 32'h00000321 || state_dbg !== 3'd3) begin errors++; $display("FAIL rst_setup: user_input %h state %0d expected 00000321 3", cpu.user_input, state_dbg); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (cpu.user_input !== 32'h0 || cpu.input_ready !== 1'b0 || cpu.cpu_stall !== 1'b0 || state_dbg !== 3'd0) begin errors++; $display("FAIL rst_async: user_input %h ready %b stall %b state %0d expected 0 0 0 0", cpu.user_input, cpu.input_ready, cpu.cpu_stall, state_dbg); end
    key_n = 1'b1;
    tick(3);
    sw = 15'h0042;
    reset = 1'b0;
    tick(2);
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL rst_rearm: got %0d expected 2", state_dbg); end
    key_n = 1'b0;
    tick(6);
    checks++; if (cpu.user_input !== 32'h00000042) begin errors++; $display("FAIL rst_capture: got %h expected %h", cpu.user_input, 32'h00000042); end
    tick(4);
    key_n = 1'b1;
    tick(7);
    checks++; if (cpu.input_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", cpu.input_ready); end
    cpu.input_flag = 1'b0;
    tick(1);
    checks++; if (ready_cnt - ready_base !== 1) begin errors++; $display("FAIL rst_pulse_count: got %0d expected 1", ready_cnt - ready_base); end
  endtask

  initial begin
    test_reset();
    test_preview();
    test_basic_read();
    test_bounce();
    test_held_rearm();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
